// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree.
// Op encoding, pad identity and tree sizing helpers.
package reduce_pkg;

    localparam logic [1:0] REDUCE_AND = 2'd0;
    localparam logic [1:0] REDUCE_OR  = 2'd1;
    localparam logic [1:0] REDUCE_XOR = 2'd2;
    localparam logic [1:0] REDUCE_RSV = 2'd3;

    // Pad value that leaves the op's result unchanged; reserved runs as AND.
    function automatic logic op_identity(input logic [1:0] op);
        return !(op == REDUCE_OR || op == REDUCE_XOR);
    endfunction

    function automatic int ceil_div(input int n, input int r);
        return (n + r - 1) / r;
    endfunction

    // Width of tree level l: W_0 = n, W_l = ceil(W_(l-1) / r).
    function automatic int level_width(input int n, input int r, input int l);
        int w;
        w = n;
        for (int i = 0; i < l; i++) begin
            w = ceil_div(w, r);
        end
        return w;
    endfunction

    // ceil(log_r(n)), never below one level.
    function automatic int clog_radix(input int n, input int r);
        int w;
        int lv;
        w  = n;
        lv = 0;
        while (w > 1) begin
            w  = ceil_div(w, r);
            lv = lv + 1;
        end
        return (lv < 1) ? 1 : lv;
    endfunction

endpackage

// File: rtl/reduce_node.sv
// One combinational tree node: RADIX inputs folded by AND/OR/XOR.
// Reserved op falls through to AND.
module reduce_node
    import reduce_pkg::*;
#(
    parameter int RADIX = 4
) (
    input  logic [1:0]       op,
    input  logic [RADIX-1:0] a,
    output logic             y
);

    // Fold the node inputs with the selected op.
    always_comb begin
        y = &a;
        unique case (op)
            REDUCE_OR:  y = |a;
            REDUCE_XOR: y = ^a;
            default:    y = &a;
        endcase
    end

endmodule

// File: rtl/reduce_pipe.sv
// Pipelined bitwise reduction tree, one register stage per level.
// Valid/ready on both ends, bubble collapsing, synchronous flush.
module reduce_pipe
    import reduce_pkg::*;
#(
    parameter int N_INS = 64,
    parameter int RADIX = 4
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [N_INS-1:0] in_a,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_op,
    output logic             out_y
);

    localparam int LEVELS = clog_radix(N_INS, RADIX);

    genvar l;
    generate
        for (l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int WI = level_width(N_INS, RADIX, l);
            localparam int WO = level_width(N_INS, RADIX, l + 1);

            logic                src_vld;
            logic [1:0]          src_op;
            logic [WI-1:0]       src;
            logic [WO*RADIX-1:0] pad;
            logic [WO-1:0]       nxt;
            logic                nxt_ld;
            logic                ld;
            logic                vld;
            logic [1:0]          op;
            logic [WO-1:0]       q;

            if (l == 0) begin : g_src
                assign src_vld = in_valid;
                assign src_op  = in_op;
                assign src     = in_a;
            end else begin : g_src
                assign src_vld = g_lvl[l-1].vld;
                assign src_op  = g_lvl[l-1].op;
                assign src     = g_lvl[l-1].q;
            end

            if (l == LEVELS - 1) begin : g_nxt
                assign nxt_ld = out_ready;
            end else begin : g_nxt
                assign nxt_ld = g_lvl[l+1].ld;
            end

            // A stage takes new data when empty or when its content moves on.
            assign ld = !vld || nxt_ld;

            // Fill the ragged top of the level with the op's identity.
            always_comb begin
                pad           = {(WO*RADIX){op_identity(src_op)}};
                pad[WI-1:0]   = src;
            end

            for (genvar j = 0; j < WO; j++) begin : g_node
                reduce_node #(
                    .RADIX(RADIX)
                ) u_node (
                    .op(src_op),
                    .a (pad[j*RADIX +: RADIX]),
                    .y (nxt[j])
                );
            end

            // Stage register; op rides along with its partial vector.
            always_ff @(posedge clk or negedge rst_aL) begin
                if (!rst_aL) begin
                    vld <= 1'b0;
                    op  <= '0;
                    q   <= '0;
                end else if (flush) begin
                    vld <= 1'b0;
                end else if (ld) begin
                    vld <= src_vld;
                    if (src_vld) begin
                        op <= src_op;
                        q  <= nxt;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = rst_aL && g_lvl[0].ld;
    assign out_valid = g_lvl[LEVELS-1].vld;
    assign out_op    = g_lvl[LEVELS-1].op;
    assign out_y     = g_lvl[LEVELS-1].q[0];

    a_no_rsv_op: assert property (
        @(posedge clk) disable iff (!rst_aL)
        !(in_valid && in_ready && in_op == REDUCE_RSV)
    );

endmodule

// File: doc/reduce_pipe.md
Name: reduce_pipe

Overview:
- Parametrised, pipelined bitwise reduction unit: successor to the fixed 2..32-input AND reducers; supports any input width, selectable AND/OR/XOR per transaction, and a configurable tree radix.
- One register stage per tree level, valid/ready handshake on both sides, bubble-collapsing backpressure and synchronous flush.
- Used wherever the core needs wide all-match or any-match detect (CAM hit vectors, ROB/IQ ready vectors, parity) without a long combinational path.

Parameters:
- N_INS, 64, number of input bits; any value >= 1.
- RADIX, 4, fan-in per tree node; legal values 2, 3, 4.
- LEVELS, derived (localparam), ceil(log_RADIX(N_INS)), minimum 1; equals pipeline depth and latency.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_aL  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  stage 0 can accept this cycle.
- in_op  in  2  operation: 0 AND, 1 OR, 2 XOR, 3 reserved.
- in_a  in  N_INS  operand bits.
- flush  in  1  synchronous kill of all in-flight transactions.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_op  out  2  op of the delivered result.
- out_y  out  1  reduction result.

Behaviour:
- One clock, clk; reset asynchronous, active-low on rst_aL. While rst_aL=0: all stage valids=0, out_valid=0, out_y=0, out_op=0, in_ready=0. After release: in_ready=1 (pipeline empty).
- Level widths: W_0=N_INS, W_l=ceil(W_(l-1)/RADIX). Each level pads its input up to a multiple of RADIX with the op identity: 1 for AND, 0 for OR/XOR. Padding never changes the result. N_INS=1: single registered pass-through level.
- Every stage register holds {valid, op, partial vector}; op travels with the data, so mixed ops may be in flight back to back.
- Advance rule: stage k loads from k-1 when (!valid_k || advance_(k+1)); the last stage advances on out_ready. in_ready = rst_aL && (!valid_0 || advance_1). Bubbles collapse; no data is lost or duplicated under backpressure.
- Latency: accepted at edge t, out_valid=1 after edge t+LEVELS-1 when no stall (LEVELS cycles from presentation to visibility). Full throughput: 1 transaction/cycle with out_ready held high.
- out_y, out_op hold stable while out_valid=1 and out_ready=0.
- in_op=3: treated as AND; a simulation assertion fires on acceptance.
- flush=1: all valids clear at the next edge. An input handshaking in the same cycle is discarded. An output that handshakes in the same cycle counts as delivered. Flush beats in_valid.
- Reset mid-operation: everything in flight is dropped immediately (asynchronous); nothing is replayed.
- Ordering is strictly FIFO.

Decomposition:
- Shared package holds the op encoding constants (REDUCE_AND/OR/XOR), an identity-of-op function, and a ceil-log helper function used to compute LEVELS and W_l.
- One sub-module, reduce_node: a combinational RADIX-input node with an op select, instantiated W_l times per level inside a generate loop.
- Stage registers and handshake logic stay in reduce_pipe.

Test Plan:
- N_INS=64, RADIX=4 (LEVELS=3): AND of all-ones, out_ready=1 -> out_y=1, out_valid exactly 3 cycles after acceptance. Repeat with only bit 37 cleared -> out_y=0.
- N_INS=10, RADIX=4: OR of 10'h000 -> 0; XOR of 10'h3FF -> 0; AND of 10'h3FF -> 1. Confirms padding identity per op.
- Back-to-back ops AND/OR/XOR on in_a=64'h1, one per cycle -> out_y sequence 0,1,1 with out_op sequence 0,1,2 on consecutive cycles.
- Backpressure: out_ready=0 for 6 cycles while 4 transactions are offered -> in_ready drops after 3 accepted. On release, the results drain in order with no loss or duplication, and the 4th is then accepted.
- flush asserted with 3 transactions in flight and in_valid=1 -> out_valid=0 the next cycle, and none of the 4 results ever appear.
- rst_aL pulsed low mid-stream -> out_valid=0 and in_ready=0 immediately (asynchronously). After release, a fresh AND of all-ones returns 1 with normal latency.
